nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (16 at default).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin an operation.
REQ-005 SHALL have port: op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-006 SHALL have ports: a, b  input  W  operands, sampled only when start is accepted.
REQ-007 SHALL have port: busy  output  1  operation in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 SHALL have ports: sum  output  W  result; cout  output  1  final carry out; ovf  output  1  signed overflow; zero  output  1  sum == 0.

Function
REQ-010 SHALL sequence a single shared 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
REQ-011 SHALL use FSM states IDLE, RUN and DONE, with a nibble index register of width clog2(NIBBLES).
REQ-012 SHALL accept start only in IDLE or DONE: latch a, b and op, clear sum, set carry register = op, set index = 0, and go to RUN.
REQ-013 SHALL ignore start while in RUN, with no effect on operands, state or outputs.
REQ-014 SHALL, in each RUN cycle, feed the slice a[idx], b[idx]^{4{op}} and the carry register, write the slice sum into sum[idx], load the carry register from slice carry-out, and increment idx.
REQ-015 SHALL go from RUN to DONE on the edge that processes idx = NIBBLES-1; for this transition, idx wrap-around is don't-care.
REQ-016 SHALL hold DONE for exactly one cycle with done = 1, then go to IDLE unless a new start is accepted in that cycle.
REQ-017 SHALL have fixed latency: with start sampled on edge 0, done is high in clock cycle NIBBLES+1 (cycle 5 at default).
REQ-018 SHALL drive busy = 1 exactly in RUN, and done = 1 exactly in DONE.
REQ-019 SHALL produce cout = final carry register; for subtract, cout = 1 means no borrow.
REQ-020 SHALL compute ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' = b ^ {W{op}}.
REQ-021 SHALL derive zero combinationally from sum.
REQ-022 SHALL hold sum, cout, ovf and zero stable from DONE until the next accepted start.
REQ-023 SHALL truncate arithmetic modulo 2^W, with no saturation.

Reset
REQ-024 SHALL, while rst = 1 on a rising edge, force state = IDLE, idx = 0, carry = 0, sum = 0, cout = 0, ovf = 0, busy = 0 and done = 0 (zero = 1).
REQ-025 SHALL abort any operation when rst is asserted mid-RUN: no done pulse, and partial sum cleared.
REQ-026 SHALL give rst priority over a simultaneous start.

Structure
REQ-027 SHALL place the state encoding (IDLE = 0, RUN = 1, DONE = 2), the op encoding (ADD = 0, SUB = 1) and NIBBLE_W = 4 in shared package nibble_seq_pkg.
REQ-028 SHALL instantiate exactly one instance of the existing 4-bit ripple-carry adder slice bpa as its sole sub-module, and contain no other adder.

Verification
REQ-029 SHALL cover: add 0x1234 + 0x0FFF -> done in cycle 5, sum = 0x2233, cout = 0, ovf = 0, zero = 0.
REQ-030 SHALL cover: add 0xFFFF + 0x0001 -> sum = 0x0000, cout = 1, zero = 1, ovf = 0.
REQ-031 SHALL cover: add 0x7FFF + 0x0001 -> sum = 0x8000, ovf = 1, cout = 0; then sub 0x0005 - 0x0007 -> sum = 0xFFFE, cout = 0, ovf = 0.
REQ-032 SHALL cover: start with a = 0x1111 during RUN of an 0xAAAA + 0x1111 operation -> ignored; result 0xBBBB, single done pulse.
REQ-033 SHALL cover: back-to-back start asserted in the DONE cycle -> accepted; second done exactly 5 cycles later; busy never low in between except during DONE.
REQ-034 SHALL cover: rst asserted in cycle 3 of RUN -> next cycle IDLE, sum = 0, busy = 0, no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/nibble_seq_pkg.sv
// nibble_seq_pkg: shared encodings for the nibble-serial adder
package nibble_seq_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_e;
endpackage

// File: rtl/nibble_add_seq_bpa.sv
// bpa: 4-bit ripple-carry adder slice
module bpa
  import nibble_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);
  logic [NIBBLE_W:0] c;
  assign c[0] = cin;
  genvar i;
  generate
    for (i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate
  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: add/subtract W-bit operands one nibble per clock through a single shared slice
module nibble_add_seq
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        op,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf,
  output logic                        zero
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d, sum_q, sum_d, bx;
  logic                carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, last;
  logic [NIBBLE_W-1:0] sl_a, sl_b, sl_s;
  logic                sl_co;
  assign bx   = b_q ^ {W{op_q == SUB}};
  assign sl_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign sl_b = bx[NIBBLE_W*idx_q +: NIBBLE_W];
  assign last = idx_q == IW'(NIBBLES - 1);
  bpa u_bpa (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .cout(sl_co)
  );
  // next state: accept start outside RUN, otherwise step one nibble per RUN cycle
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (start && state_q != RUN) begin
      state_d = RUN;
      op_d    = op_e'(op);
      idx_d   = '0;
      a_d     = a;
      b_d     = b;
      sum_d   = '0;
      carry_d = op;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = sl_s;
      carry_d = sl_co;
      idx_d   = idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        cout_d  = sl_co;
        ovf_d   = (a_q[W-1] == bx[W-1]) && (sl_s[NIBBLE_W-1] != a_q[W-1]);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state registers with reset aborting any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= ADD;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = sum_q == '0;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed vectors checked against an arithmetic reference model every cycle
module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 1'b0;
  logic rst, start, op, busy, done, cout, ovf, zero;
  logic [W-1:0] a, b, sum;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // reference model: age counts cycles since an accepted start; results from plain arithmetic
  int           age = -1;
  bit           armed = 0;
  bit           res_valid = 0;
  logic [W-1:0] e_sum, p_sum;
  logic         e_cout, e_ovf, p_cout, p_ovf;
  always @(posedge clk) begin
    if (rst) begin
      armed     = 1;
      age       = -1;
      res_valid = 1;
      e_sum     = '0;
      e_cout    = 0;
      e_ovf     = 0;
    end else if (armed) begin
      if (start && !(age >= 1 && age <= N)) begin
        int sa, sb, r;
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        r      = op ? sa - sb : sa + sb;
        p_ovf  = r > 32767 || r < -32768;
        p_sum  = op ? W'(a - b) : W'(a + b);
        p_cout = op ? (a >= b) : ({1'b0, a} + {1'b0, b} > 17'h0FFFF);
        age       = 1;
        res_valid = 0;
      end else if (age >= 1 && age <= N + 1) begin
        age++;
        if (age == N + 1) begin
          e_sum     = p_sum;
          e_cout    = p_cout;
          e_ovf     = p_ovf;
          res_valid = 1;
        end
      end
    end
  end
  // compare DUT to model on every falling edge once reset has been seen
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(age >= 1 && age <= N));
      chk("done", 32'(done), 32'(age == N + 1));
      if (res_valid) begin
        chk("sum", 32'(sum), 32'(e_sum));
        chk("cout", 32'(cout), 32'(e_cout));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("zero", 32'(zero), 32'(e_sum == '0));
      end
    end
  end
  task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic run(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
    int c;
    launch(o, x, y);
    wait_done(1, c);
    chk("latency", c, N + 1);
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("lit_ovf", 32'(ovf), 32'(eo));
    chk("lit_zero", 32'(zero), 32'(ez));
  endtask
  initial begin
    int c, pulses, gaps;
    rst = 1; start = 0; op = 0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 0;
    run(0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 0);
    run(0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
    run(0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
    run(1, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 0);
    run(1, 16'h0000, 16'h8000, 16'h8000, 0, 1, 0);
    // start during RUN must be ignored
    launch(0, 16'hAAAA, 16'h1111);
    @(negedge clk);
    start = 1; op = 1; a = 16'h1111; b = 16'h0000;
    @(negedge clk);
    start = 0;
    wait_done(3, c);
    chk("ign_latency", c, N + 1);
    chk("ign_sum", 32'(sum), 32'h0000BBBB);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("ign_extra_done", pulses, 0);
    // back-to-back start in the DONE cycle
    launch(0, 16'h0101, 16'h0202);
    wait_done(1, c);
    chk("b2b_lat1", c, N + 1);
    chk("b2b_sum1", 32'(sum), 32'h00000303);
    start = 1; op = 1; a = 16'h0010; b = 16'h0001;
    @(negedge clk);
    start = 0;
    gaps = 0;
    c = 1;
    while (done !== 1'b1 && c < 20) begin
      if (!busy) gaps++;
      @(negedge clk);
      c++;
    end
    chk("b2b_lat2", c, N + 1);
    chk("b2b_busy_gap", gaps, 0);
    chk("b2b_sum2", 32'(sum), 32'h0000000F);
    chk("b2b_cout2", 32'(cout), 1);
    // reset in the third RUN cycle aborts the operation
    launch(0, 16'h1234, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_zero", 32'(zero), 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run(0, 16'h4321, 16'h1111, 16'h5432, 0, 0, 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
